// File: rtl/gray_filter_engine.sv
// Frame sweep engine: reads a frozen grayscale frame, applies a per-pixel filter
// and writes the result in place into a second frame buffer, one pixel per cycle.
module gray_filter_engine #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [2:0]  filter_sel_in,
    input  logic [3:0]  threshold_in,
    output logic [16:0] rd_addr_out,
    input  logic [3:0]  rd_data_in,
    output logic [16:0] wr_addr_out,
    output logic [3:0]  wr_data_out,
    output logic        wr_en_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned DW   = $clog2(RD_LATENCY + 2);
    localparam int unsigned PTAP = RD_LATENCY - 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q;
    logic [2:0]    sel_q;
    logic [3:0]    thr_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [16:0]   addr_q;
    logic          rvld_q;
    logic [DW-1:0] drain_q;
    logic          busy_q;
    logic          done_q;

    logic          vld_sr   [RD_LATENCY];
    logic          first_sr [RD_LATENCY];
    logic [16:0]   addr_sr  [RD_LATENCY];

    logic [3:0]    prev_q;
    logic [3:0]    filt_d;
    logic          wr_en_q;
    logic [16:0]   wr_addr_q;
    logic [3:0]    wr_data_q;

    // Control FSM; rd_addr_out is the registered scan address, valid while rvld_q.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            sel_q   <= '0;
            thr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            rvld_q  <= 1'b0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // done_q still high means this is the done cycle: start is ignored.
                    if (start_in && !done_q) begin
                        sel_q   <= filter_sel_in;
                        thr_q   <= threshold_in;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        rvld_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (row_q == ROW_LAST) begin
                            rvld_q  <= 1'b0;
                            drain_q <= '0;
                            state_q <= DRAIN;
                        end else begin
                            row_q  <= row_q + RW'(1);
                            addr_q <= addr_q + 17'd1;
                        end
                    end else begin
                        col_q  <= col_q + CW'(1);
                        addr_q <= addr_q + 17'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Filter on the tagged read data; edge uses the previous pixel of the same row only.
    always_comb begin
        filt_d = rd_data_in;
        case (sel_q)
            3'd1: filt_d = 4'hF - rd_data_in;
            3'd2: filt_d = (rd_data_in >= thr_q) ? 4'hF : 4'h0;
            3'd3: filt_d = {rd_data_in[3:2], 2'b00};
            3'd4: begin
                if (first_sr[PTAP]) begin
                    filt_d = '0;
                end else if (rd_data_in >= prev_q) begin
                    filt_d = rd_data_in - prev_q;
                end else begin
                    filt_d = prev_q - rd_data_in;
                end
            end
            default: filt_d = rd_data_in;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                vld_sr[i]   <= 1'b0;
                first_sr[i] <= 1'b0;
                addr_sr[i]  <= '0;
            end
            prev_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_sr[0]   <= rvld_q;
            first_sr[0] <= (col_q == '0);
            addr_sr[0]  <= addr_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
            wr_en_q <= vld_sr[PTAP];
            if (vld_sr[PTAP]) begin
                wr_addr_q <= addr_sr[PTAP];
                wr_data_q <= filt_d;
                prev_q    <= rd_data_in;
            end
        end
    end

    assign rd_addr_out = addr_q;
    assign wr_addr_out = wr_addr_q;
    assign wr_data_out = wr_data_q;
    assign wr_en_out   = wr_en_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;

endmodule

// File: doc/gray_filter_engine.md
Name: gray_filter_engine

Overview:
- Post-capture processing stage, directly downstream of the start/select screen.
- Once the select screen signals completion and reports the chosen filter, this block sweeps the frozen 320x240 grayscale frame buffer on clk_65mhz.
- It applies the selected per-pixel filter and writes the results into a second 320x240 result BRAM, which the VGA path displays.
- Start/busy/done handshake; one pixel per cycle, fully pipelined across the BRAM read latency.

Parameters:
WIDTH, 320, frame width in pixels
HEIGHT, 240, frame height in pixels
RD_LATENCY, 2, cycles from rd_addr_out to valid rd_data_in (BRAM with output register)

Ports:
clk_in  input  1  system clock (65 MHz)
rst_in  input  1  synchronous active-high reset
start_in  input  1  single-cycle request to process one frame
filter_sel_in  input  3  filter select: 0 pass, 1 invert, 2 threshold, 3 posterize, 4 horizontal edge, 5-7 pass
threshold_in  input  4  threshold for filter 2
rd_addr_out  output  17  source BRAM read address
rd_data_in  input  4  source gray pixel
wr_addr_out  output  17  result BRAM write address
wr_data_out  output  4  filtered pixel
wr_en_out  output  1  result write strobe
busy_out  output  1  high while a frame is in progress
done_out  output  1  single-cycle pulse when the last pixel has been written

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- The clock and reset are one clock, synchronous, active-high: clk_in / rst_in.
- FSM states:
  - IDLE: on start_in, latch filter_sel_in and threshold_in into internal registers (held constant for the frame), zero the column/row counters, set busy_out=1, go to RUN.
  - RUN: each cycle, issue rd_addr_out = row*WIDTH + col, then increment col. Col wraps at WIDTH-1 -> 0 with row+1. After issuing address WIDTH*HEIGHT-1 (76799), go to DRAIN.
  - DRAIN: wait RD_LATENCY+1 cycles for the pipeline to empty, then go to DONE.
  - DONE: pulse done_out for 1 cycle, drop busy_out, return to IDLE.
- Pipeline:
  - A valid/col/address shift register of depth RD_LATENCY accompanies each read.
  - When the tagged data arrives, the filter is computed and registered.
  - wr_en_out, wr_addr_out and wr_data_out assert together exactly RD_LATENCY+1 cycles after the corresponding rd_addr_out.
  - wr_addr_out equals the read address (in-place mapping).
- Filters (4-bit p):
  - pass: p
  - invert: 15-p
  - threshold: (p >= thr) ? 15 : 0
  - posterize: {p[3:2],2'b00}
  - edge: |p - p_prev|, unsigned 4-bit, where p_prev is the previous pixel in the same row; output 0 at col 0 (p_prev never crosses rows).
- Exactly WIDTH*HEIGHT writes per frame, with no gaps or repeats.
- start_in while busy is ignored: no restart, and the latched settings are unchanged.
- start_in in the same cycle as done_out is ignored; a new start is accepted in IDLE on the cycle after done_out.
- Changing filter_sel_in or threshold_in mid-frame has no effect.
- rst_in mid-frame aborts immediately: the next cycle shows IDLE, wr_en_out=0, busy_out=0, and no done pulse.
- Start-to-done latency is WIDTH*HEIGHT + RD_LATENCY + 3 cycles (76805 at defaults).

Test Plan:
- Pass, ramp source (data = addr[3:0]), RD_LATENCY=2: expect 76800 writes, wr_data == wr_addr[3:0], first wr_en 3 cycles after first read, done_out one cycle only, busy low afterwards.
- Invert on constant 4: every wr_data = 11. Threshold thr=8 on source 7/8 alternating: outputs 0/15 alternating.
- Edge on a row pattern 0,5,2,15,...: outputs 0,5,3,13; first pixel of every row = 0 even when the previous row ended at 15.
- Posterize on p=13: expect 12. filter_sel_in=6: expect pass-through.
- start_in pulsed at cycle 1000 of a frame, plus filter_sel_in changed mid-frame: exactly 76800 writes, original filter used, single done.
- rst_in at pixel 500: next cycle busy=0, wr_en=0, no done; a fresh start then produces a complete correct frame starting at address 0.
